// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache with one-word blocks.
// Hits are answered combinationally in IDLE. A miss starts one fill, which
// always finishes to the latched miss address. iflush invalidates every frame.
// Optional build macro ICACHE_STATS_EN adds the hit_cnt and miss_cnt counters.
module icache_direct #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              iflush,
    output logic              ihit,
    output logic [ADDR_W-1:0] imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [ADDR_W-1:0] iload,
`ifdef ICACHE_STATS_EN
    input  logic              iwait,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    input  logic              iwait
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic [ADDR_W-3:0]       miss_word;   // word address of the outstanding fill
    logic [SETS-1:0]         valid;
    logic [TAG_W-1:0]        tags [SETS];
    logic [ADDR_W-1:0]       data [SETS];

    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    miss_start;
    logic                    fill_done;
    logic                    unused_byte_off;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[ADDR_W-1:IDX_W+2];
    assign fill_idx = miss_word[IDX_W-1:0];
    assign fill_tag = miss_word[ADDR_W-3:IDX_W];
    // The fetch PC is word aligned, so its byte offset carries no information.
    assign unused_byte_off = ^imemaddr[1:0];

    // Lookup: only IDLE can report a hit, so a line being refilled is never bypassed.
    always_comb begin
        hit      = 1'b0;
        imemload = '0;
        if (state == IDLE && imemREN && valid[req_idx] && tags[req_idx] == req_tag) begin
            hit      = 1'b1;
            imemload = data[req_idx];
        end
    end

    assign ihit       = hit;
    assign miss_start = (state == IDLE) && imemREN && !hit && !iflush;
    assign fill_done  = (state == FILL) && !iwait && !RST;
    assign iREN       = (state == FILL);
    assign iaddr      = (state == FILL) ? {miss_word, 2'b00} : '0;

    // Control FSM and valid bits. A flush wins over the valid set of a completing fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_word <= '0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        state     <= FILL;
                        miss_word <= imemaddr[ADDR_W-1:2];
                    end
                end
                FILL: begin
                    if (!iwait) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (iflush)
                valid <= '0;
            else if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written on fill completion, even when a flush drops the valid bit.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Statistics: hit cycles and miss starts, both wrapping at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)        hit_cnt  <= hit_cnt + 32'd1;
            if (miss_start) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: table-driven directed test of icache_direct.
// Each table row is one clock cycle: inputs driven after negedge, outputs
// compared before the following posedge.
module tb_icache_direct;
    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    icache_direct #(.SETS(16), .ADDR_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
`ifdef ICACHE_STATS_EN
        .iwait    (iwait),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`else
        .iwait    (iwait)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        flush;
        logic        wait_;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic ren, logic [31:0] addr, logic flush,
                                logic wt, logic [31:0] load, logic e_hit,
                                logic [31:0] e_load, logic e_iren, logic [31:0] e_iaddr);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.flush = flush; v.wait_ = wt;
        v.load = load; v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren;
        v.e_iaddr = e_iaddr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic apply(vec_t v, int row);
        @(negedge CLK);
        RST = v.rst; imemREN = v.ren; imemaddr = v.addr; iflush = v.flush;
        iwait = v.wait_; iload = v.load;
        #1;
        check($sformatf("row%0d ihit", row),     {31'd0, ihit}, {31'd0, v.e_hit});
        check($sformatf("row%0d imemload", row), imemload,      v.e_load);
        check($sformatf("row%0d iREN", row),     {31'd0, iREN}, {31'd0, v.e_iren});
        check($sformatf("row%0d iaddr", row),    iaddr,         v.e_iaddr);
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0; iload = '0;
        repeat (2) @(posedge CLK);

        //                rst ren addr          fl wt load           hit load           iren iaddr
        // reset state
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        // cold miss at 0x40, one-cycle fill, hit two cycles after request
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         1, 32'h2001_0005, 0, 32'h0));
        // conflict: 0x440 shares index 0, evicts, then 0x40 re-misses
        tbl.push_back(mk(0, 1, 32'h0000_0440, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0440, 0, 0, 32'hDEAD_0440, 0, 32'h0,         1, 32'h440));
        tbl.push_back(mk(0, 1, 32'h0000_0440, 0, 0, 32'h0,         1, 32'hDEAD_0440, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         1, 32'h2001_0005, 0, 32'h0));
        // flush in IDLE with no request, then 0x40 misses
        tbl.push_back(mk(0, 0, 32'h0000_0040, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
        foreach (tbl[i]) apply(tbl[i], i);

        // iwait held 5 cycles while the fetch PC moves to 0x80: fill stays on 0x40
        for (int k = 0; k < 5; k++)
            apply(mk(0, 1, 32'h0000_0080, 0, 1, 32'hBAD0_BAD0, 0, 32'h0, 1, 32'h40), 100 + k);
        apply(mk(0, 1, 32'h0000_0080, 0, 0, 32'h1111_0040, 0, 32'h0,         1, 32'h40), 105);
        apply(mk(0, 1, 32'h0000_0040, 0, 0, 32'h0,         1, 32'h1111_0040, 0, 32'h0),  106);
        apply(mk(0, 1, 32'h0000_0080, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  107);
        apply(mk(0, 1, 32'h0000_0080, 0, 0, 32'h2222_0080, 0, 32'h0,         1, 32'h80), 108);
        apply(mk(0, 1, 32'h0000_0080, 0, 0, 32'h0,         1, 32'h2222_0080, 0, 32'h0),  109);

        // flush in the fill-completion cycle: line written but not valid
        apply(mk(0, 1, 32'h0000_0044, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  200);
        apply(mk(0, 1, 32'h0000_0044, 1, 0, 32'h3333_0044, 0, 32'h0,         1, 32'h44), 201);
        apply(mk(0, 1, 32'h0000_0044, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  202);
        apply(mk(0, 1, 32'h0000_0044, 0, 0, 32'h3333_0044, 0, 32'h0,         1, 32'h44), 203);
        apply(mk(0, 1, 32'h0000_0044, 0, 0, 32'h0,         1, 32'h3333_0044, 0, 32'h0),  204);
        // flush in IDLE on a cold address: no fill is started
        apply(mk(0, 1, 32'h0000_0048, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0),  205);
        apply(mk(0, 0, 32'h0000_0048, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  206);

        // reset in the middle of a fill
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  300);
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h4444_0048, 0, 32'h0,         1, 32'h48), 301);
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h0,         1, 32'h4444_0048, 0, 32'h0),  302);
        apply(mk(0, 1, 32'h0000_004C, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  303);
        apply(mk(0, 1, 32'h0000_004C, 0, 1, 32'h0,         0, 32'h0,         1, 32'h4C), 304);
        apply(mk(1, 1, 32'h0000_004C, 0, 0, 32'h9999_004C, 0, 32'h0,         1, 32'h4C), 305);
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  306);
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h5555_0048, 0, 32'h0,         1, 32'h48), 307);
        apply(mk(0, 1, 32'h0000_0048, 0, 0, 32'h0,         1, 32'h5555_0048, 0, 32'h0),  308);
        apply(mk(0, 1, 32'h0000_004C, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  309);
        apply(mk(0, 0, 32'h0000_004C, 0, 0, 32'h6666_004C, 0, 32'h0,         1, 32'h4C), 310);
        apply(mk(0, 0, 32'h0000_004C, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0),  311);

`ifdef ICACHE_STATS_EN
        // counters: 3 misses, then 3 + 3 + 4 hit cycles
        apply(mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), 400);
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), 401);
        check("hit_cnt after reset",  hit_cnt,  32'd0);
        check("miss_cnt after reset", miss_cnt, 32'd0);
        for (int m = 0; m < 3; m++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(m * 4);
            apply(mk(0, 1, a, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0), 410 + m * 10);
            apply(mk(0, 1, a, 0, 0, 32'h7000 + a, 0, 32'h0,       1, a),     411 + m * 10);
            for (int h = 0; h < ((m == 2) ? 4 : 3); h++)
                apply(mk(0, 1, a, 0, 0, 32'h0, 1, 32'h7000 + a, 0, 32'h0), 412 + m * 10 + h);
        end
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), 450);
        check("miss_cnt", miss_cnt, 32'd3);
        check("hit_cnt",  hit_cnt,  32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends with a summary line.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
